// File: rtl/mux_tree_pipe_pkg.sv
// Shared sizing helpers for the pipelined radix-4 selector tree.
package mux_tree_pkg;

  localparam int MUX_RADIX = 4;

  // Number of radix-4 levels needed to reduce n inputs to one.
  function automatic int clog4(input int n);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < 16; i++) begin
      if (p < n) begin
        p = p * MUX_RADIX;
        r++;
      end
    end
    return r;
  endfunction

  // Lane count produced by tree level `level`.
  function automatic int lanes_at(input int level, input int channels);
    int span;
    span = MUX_RADIX;
    for (int i = 0; i < level; i++) span = span * MUX_RADIX;
    return (channels + span - 1) / span;
  endfunction

endpackage

// File: rtl/mux_tree_pipe_mux4_stage.sv
// One registered radix-4 reduction level with valid/ready handshake.
module mux4_stage
  import mux_tree_pkg::*;
#(
  parameter  int IN_LANES  = 4,
  parameter  int WIDTH     = 1,
  parameter  int SEL_IN_W  = 2,
  localparam int OUT_LANES = (IN_LANES + MUX_RADIX - 1) / MUX_RADIX,
  localparam int SEL_USE   = (SEL_IN_W >= 2) ? 2 : 1,
  localparam int SEL_OUT_W = (SEL_IN_W > SEL_USE) ? SEL_IN_W - SEL_USE : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             up_valid_i,
  output logic                             up_ready_o,
  input  logic [IN_LANES-1:0][WIDTH-1:0]   up_data_i,
  input  logic [SEL_IN_W-1:0]              up_sel_i,
  input  logic                             up_err_i,
  output logic                             dn_valid_o,
  input  logic                             dn_ready_i,
  output logic [OUT_LANES-1:0][WIDTH-1:0]  dn_data_o,
  output logic [SEL_OUT_W-1:0]             dn_sel_o,
  output logic                             dn_err_o
);

  localparam int PAD = OUT_LANES * MUX_RADIX;

  logic [PAD-1:0][WIDTH-1:0]       pad;
  logic [1:0]                      pick;
  logic [OUT_LANES-1:0][WIDTH-1:0] data_d, data_q;
  logic [SEL_OUT_W-1:0]            sel_d, sel_q;
  logic                            valid_q, err_q;
  logic                            load;

  // A single remaining sel bit leaves the upper pair of each group unreachable.
  if (SEL_USE == 2) begin : g_pick2
    assign pick = up_sel_i[1:0];
  end else begin : g_pick1
    assign pick = {1'b0, up_sel_i[0]};
  end

  if (SEL_IN_W > SEL_USE) begin : g_sel
    assign sel_d = up_sel_i[SEL_IN_W-1:SEL_USE];
  end else begin : g_nosel
    assign sel_d = '0;
  end

  // Partial groups see zeros; an out-of-range request zeroes every lane.
  always_comb begin
    pad = '0;
    pad[IN_LANES-1:0] = up_data_i;
    data_d = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      if (!up_err_i) data_d[j] = pad[j*MUX_RADIX + int'(pick)];
    end
  end

  assign up_ready_o = !valid_q || dn_ready_i;
  assign load       = up_valid_i && up_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data_d;
      sel_q   <= sel_d;
      err_q   <= up_err_i;
    end else if (dn_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;
  assign dn_sel_o   = sel_q;
  assign dn_err_o   = err_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 channel selector: radix-4 tree, one register level per
// tree level, elastic valid/ready handshake, out-of-range select flagged.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter  int CHANNELS = 32,
  parameter  int WIDTH    = 1,
  localparam int SEL_W    = $clog2(CHANNELS),
  localparam int LEVELS   = clog4(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          in_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_err
);

  logic [CHANNELS-1:0][WIDTH-1:0] in_lanes;
  logic [LEVELS:0]                vld_pipe;
  logic [LEVELS:0]                rdy;
  logic                           err0;
  logic                           unused_sel;

  assign in_lanes         = in_data;
  assign err0             = int'(in_sel) >= CHANNELS;
  assign vld_pipe[0]      = in_valid;
  assign rdy[LEVELS]      = out_ready;
  assign in_ready         = rdy[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int IN_L = (k == 0) ? CHANNELS : lanes_at(k - 1, CHANNELS);
    localparam int OUT_L = lanes_at(k, CHANNELS);
    localparam int SI_W = SEL_W - 2 * k;
    localparam int SO_W = (SI_W > 2) ? SI_W - 2 : 1;

    logic [IN_L-1:0][WIDTH-1:0]  up_dat;
    logic [SI_W-1:0]             up_sel;
    logic                        up_err;
    logic [OUT_L-1:0][WIDTH-1:0] dat;
    logic [SO_W-1:0]             sel;
    logic                        err;

    if (k == 0) begin : g_head
      assign up_dat = in_lanes;
      assign up_sel = in_sel;
      assign up_err = err0;
    end else begin : g_link
      assign up_dat = g_lvl[k-1].dat;
      assign up_sel = g_lvl[k-1].sel;
      assign up_err = g_lvl[k-1].err;
    end

    mux4_stage #(
      .IN_LANES (IN_L),
      .WIDTH    (WIDTH),
      .SEL_IN_W (SI_W)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid_i (vld_pipe[k]),
      .up_ready_o (rdy[k]),
      .up_data_i  (up_dat),
      .up_sel_i   (up_sel),
      .up_err_i   (up_err),
      .dn_valid_o (vld_pipe[k+1]),
      .dn_ready_i (rdy[k+1]),
      .dn_data_o  (dat),
      .dn_sel_o   (sel),
      .dn_err_o   (err)
    );
  end

  // The last level has no select bits left to hand on.
  assign unused_sel = ^g_lvl[LEVELS-1].sel;

  assign out_valid = vld_pipe[LEVELS];
  assign out_data  = g_lvl[LEVELS-1].dat[0];
  assign out_err   = g_lvl[LEVELS-1].err;

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N-to-1 selector built as a radix-4 tree, one register stage per tree level, with valid/ready flow control. Successor to the flat combinational 32:1 selector in the datapath: generalised in channel count and data width, adds registered outputs, backpressure, and out-of-range select detection. Sits between the channel sample bank and downstream consumers that need one selected channel per transaction.

## Interface
- `CHANNELS`, default 32: number of input channels; 2 to 256.
- `WIDTH`, default 1: bits per channel.
- `SEL_W`, derived `$clog2(CHANNELS)`: select width; not overridable.
- `LEVELS`, derived `ceil(SEL_W/2)`: tree depth, equal to the pipeline latency.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `in_valid  in  1`: request present.
- `in_ready  out  1`: request accepted when `in_valid && in_ready`.
- `in_data  in  CHANNELS*WIDTH`: channel c occupies bits `[c*WIDTH +: WIDTH]`.
- `in_sel  in  SEL_W`: channel index.
- `out_valid  out  1`: result present.
- `out_ready  in  1`: consumer accepts.
- `out_data  out  WIDTH`: selected channel.
- `out_err  out  1`: `in_sel >= CHANNELS` for this result; `out_data` is 0.

## Operation
- Level k (k = 0..LEVELS-1) consumes `sel[2k+1:2k]` and reduces groups of 4 into 1. Level k has `ceil(CHANNELS/4^(k+1))` lanes.
- Missing inputs in a partial group are zero.
- At the top level with odd `SEL_W`, only one sel bit is used, and the upper mux input pair is zero.
- Each level registers:
  - its lane outputs;
  - the unconsumed sel bits `sel[SEL_W-1:2k+2]`;
  - an err bit, computed once at level 0 as `in_sel >= CHANNELS` and carried through;
  - a valid bit.
- When err is set, level 0 forces all of its lanes to 0, so `out_data` is 0.
- Flow control per stage: `ready[k] = !valid[k] || ready[k+1]`, where `ready[LEVELS] = out_ready` and `in_ready = ready[0]`.
- A stage loads when its upstream valid and `ready[k]` are both high. Valid clears when the stage drains with nothing loading.
- Data and sel registers load only on accept. They hold otherwise.
- Bubbles collapse: a stall at the output does not block stages that are empty.
- Output is `out_valid = valid[LEVELS-1]`, taken directly from registers, with no combinational path from `in_*` to `out_*`.
- `in_ready` depends combinationally on `out_ready`. This is accepted.

## Timing
- Reset (async assert, sync deassert handled upstream): all valid bits go to 0. `out_valid=0`, `out_data=0`, `out_err=0`. `in_ready` is 1 immediately after reset.
- Latency: an input accepted at edge t gives `out_valid` high after edge t+LEVELS-1. That is LEVELS cycles, or 3 for the defaults.
- Throughput: one result per cycle when `out_ready` is held high.
- Stall: while `out_valid && !out_ready`, `out_data` and `out_err` are stable. Up to LEVELS transactions are buffered, then `in_ready` drops.
- Simultaneous drain and load at a full stage: the new data is captured in the same cycle with no bubble.
- Reset asserted mid-stream: all in-flight transactions are discarded, nothing is emitted after reset, and the output registers clear immediately.
- `in_data` and `in_sel` are don't-care when `in_valid=0`. They must not change the state.

## Structure
- The package `mux_tree_pkg` holds:
  - the function `clog4(n)`;
  - the function `lanes_at(level, channels)`;
  - the constant `MUX_RADIX = 4`.
- The sub-module `mux4_stage`: a parametrised one-level stage with inputs (lanes, WIDTH, remaining sel width), the valid/ready handshake and the registers.
- The top generates LEVELS instances of `mux4_stage` plus the level-0 err logic.

## Test plan
- **Defaults, sweep:** `in_data=32'hA5F0_3C69`; sel 0..31 back-to-back with `out_ready=1`.
  - `out_data` equals `in_data[sel]`.
  - First `out_valid` appears 3 cycles after the first accept.
  - One result per cycle after that, in order.
- **Backpressure:** hold `out_ready=0` while streaming sel 5,6,7,8.
  - `in_ready` falls after 3 accepts.
  - `out_data` holds the sel=5 value.
  - On release, results drain in order 5,6,7,8 with no loss or duplication.
- **Non-power-of-4:** `CHANNELS=20`, `WIDTH=8`, channel c = c+8'h10.
  - sel=19 returns `8'h23`.
  - sel=20 and sel=31 return data 0 with `out_err=1`.
- **Minimum size:** `CHANNELS=2`, `LEVELS=1`.
  - sel=1 returns channel 1 after 1 cycle.
- **Reset mid-flight:** pull `rst_n` low with 3 transactions in flight.
  - `out_valid` drops asynchronously.
  - After release, no stale result appears.
  - The next request gives the correct value at latency 3.
- **Bubbles:** alternate `in_valid` and toggle `out_ready` randomly over 1000 cycles.
  - The scoreboard shows results in order, matching a reference model, with `out_data` stable whenever `out_valid && !out_ready`.
